rv_mc_control: RTL and testbench

RV_MC_CONTROL -- requirements
Module: rv_mc_control

---
 rtl/rv_mc_control.sv | 301 ++++++++++++++++++++++++++++++
 tb/tb_rv_mc_control.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_mc_control.sv
// Multi-cycle RV32I (+ optional MUL) control FSM sequencing fetch, decode, execute, memory and write-back.
// Latency: 5 cycles IF..WB for ALU ops; loads/stores/MUL add cycles, stalled handshakes stretch wait states.
// Backpressure: each wait state holds its request stable until valid/ready meet; same-cycle completion has no bubble.
module rv_mc_control #(
    parameter int CNT_W   = 32,
    parameter int M_EXT   = 0,
    parameter int MUL_LAT = 3
) (
    input  logic             clk,
    input  logic             rst,
    output logic             inst_req_valid,
    input  logic             inst_req_ready,
    input  logic             inst_valid,
    output logic             inst_ready,
    input  logic [31:0]      inst,
    output logic [31:0]      ir,
    output logic             mem_read,
    output logic             mem_write,
    input  logic             mem_req_ready,
    input  logic             read_data_valid,
    output logic             read_data_ready,
    output logic [10:0]      alu_op,
    output logic [4:0]       imm_sel,
    output logic             pc_wen,
    output logic             pc_jump,
    output logic             branch,
    output logic             rf_wen,
    output logic             illegal,
    output logic [8:0]       state,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] inst_cnt
);

    typedef enum logic [8:0] {
        S_INIT = 9'b000000001,
        S_IF   = 9'b000000010,
        S_IW   = 9'b000000100,
        S_ID   = 9'b000001000,
        S_EX   = 9'b000010000,
        S_ST   = 9'b000100000,
        S_LD   = 9'b001000000,
        S_RDW  = 9'b010000000,
        S_WB   = 9'b100000000
    } state_t;

    localparam logic [10:0] ALU_ADD  = 11'h001;
    localparam logic [10:0] ALU_SUB  = 11'h002;
    localparam logic [10:0] ALU_SLT  = 11'h004;
    localparam logic [10:0] ALU_SLTU = 11'h008;
    localparam logic [10:0] ALU_AND  = 11'h010;
    localparam logic [10:0] ALU_OR   = 11'h020;
    localparam logic [10:0] ALU_XOR  = 11'h040;
    localparam logic [10:0] ALU_SLL  = 11'h080;
    localparam logic [10:0] ALU_SRL  = 11'h100;
    localparam logic [10:0] ALU_SRA  = 11'h200;
    localparam logic [10:0] ALU_MUL  = 11'h400;

    localparam logic [4:0] IMM_U = 5'h01;
    localparam logic [4:0] IMM_J = 5'h02;
    localparam logic [4:0] IMM_I = 5'h04;
    localparam logic [4:0] IMM_B = 5'h08;
    localparam logic [4:0] IMM_S = 5'h10;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    localparam logic [3:0] MUL_LAST = 4'(MUL_LAT - 1);

    state_t      cur_state;
    state_t      next_state;
    logic [3:0]  mul_cnt;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        dec_ok;
    logic [10:0] dec_alu;
    logic [4:0]  dec_imm;
    logic        is_branch;
    logic        is_jump;
    logic        is_load;
    logic        is_store;
    logic        is_mul;
    logic        decode_active;

    assign opcode = ir[6:0];
    assign funct3 = ir[14:12];
    assign funct7 = ir[31:25];

    always_comb begin
        dec_ok    = 1'b0;
        dec_alu   = '0;
        dec_imm   = '0;
        is_branch = 1'b0;
        is_jump   = 1'b0;
        is_load   = 1'b0;
        is_store  = 1'b0;
        is_mul    = 1'b0;
        case (opcode)
            OP_LUI, OP_AUIPC: begin
                dec_ok  = 1'b1;
                dec_alu = ALU_ADD;
                dec_imm = IMM_U;
            end
            OP_JAL: begin
                dec_ok  = 1'b1;
                dec_alu = ALU_ADD;
                dec_imm = IMM_J;
                is_jump = 1'b1;
            end
            OP_JALR: begin
                dec_ok  = (funct3 == 3'b000);
                dec_alu = ALU_ADD;
                dec_imm = IMM_I;
                is_jump = 1'b1;
            end
            OP_BRANCH: begin
                dec_imm   = IMM_B;
                is_branch = 1'b1;
                case (funct3)
                    3'b000, 3'b001: begin dec_ok = 1'b1; dec_alu = ALU_SUB;  end
                    3'b100, 3'b101: begin dec_ok = 1'b1; dec_alu = ALU_SLT;  end
                    3'b110, 3'b111: begin dec_ok = 1'b1; dec_alu = ALU_SLTU; end
                    default: ;
                endcase
            end
            OP_LOAD: begin
                dec_ok  = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
                dec_alu = ALU_ADD;
                dec_imm = IMM_I;
                is_load = 1'b1;
            end
            OP_STORE: begin
                dec_ok   = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
                dec_alu  = ALU_ADD;
                dec_imm  = IMM_S;
                is_store = 1'b1;
            end
            OP_IMM: begin
                dec_imm = IMM_I;
                dec_ok  = 1'b1;
                case (funct3)
                    3'b000: dec_alu = ALU_ADD;
                    3'b010: dec_alu = ALU_SLT;
                    3'b011: dec_alu = ALU_SLTU;
                    3'b100: dec_alu = ALU_XOR;
                    3'b110: dec_alu = ALU_OR;
                    3'b111: dec_alu = ALU_AND;
                    3'b001: begin
                        dec_alu = ALU_SLL;
                        dec_ok  = (funct7 == 7'b0000000);
                    end
                    default: begin
                        dec_alu = (funct7[5]) ? ALU_SRA : ALU_SRL;
                        dec_ok  = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
                    end
                endcase
            end
            OP_REG: begin
                if (funct7 == 7'b0000000) begin
                    dec_ok = 1'b1;
                    case (funct3)
                        3'b000:  dec_alu = ALU_ADD;
                        3'b001:  dec_alu = ALU_SLL;
                        3'b010:  dec_alu = ALU_SLT;
                        3'b011:  dec_alu = ALU_SLTU;
                        3'b100:  dec_alu = ALU_XOR;
                        3'b101:  dec_alu = ALU_SRL;
                        3'b110:  dec_alu = ALU_OR;
                        default: dec_alu = ALU_AND;
                    endcase
                end else if (funct7 == 7'b0100000) begin
                    if (funct3 == 3'b000) begin
                        dec_ok  = 1'b1;
                        dec_alu = ALU_SUB;
                    end else if (funct3 == 3'b101) begin
                        dec_ok  = 1'b1;
                        dec_alu = ALU_SRA;
                    end
                end else if (funct7 == 7'b0000001 && funct3 == 3'b000 && M_EXT != 0) begin
                    dec_ok  = 1'b1;
                    dec_alu = ALU_MUL;
                    is_mul  = 1'b1;
                end
            end
            default: ;
        endcase
        // Undecodable words must not leak partial controls into the datapath.
        if (!dec_ok) begin
            dec_alu   = '0;
            dec_imm   = '0;
            is_branch = 1'b0;
            is_jump   = 1'b0;
            is_load   = 1'b0;
            is_store  = 1'b0;
            is_mul    = 1'b0;
        end
    end

    assign decode_active = (cur_state != S_INIT) && (cur_state != S_IF) && (cur_state != S_IW);
    assign alu_op  = decode_active ? dec_alu : '0;
    assign imm_sel = decode_active ? dec_imm : '0;
    assign state   = cur_state;

    always_comb begin
        next_state      = cur_state;
        inst_req_valid  = 1'b0;
        inst_ready      = 1'b0;
        pc_wen          = 1'b0;
        pc_jump         = 1'b0;
        branch          = 1'b0;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        read_data_ready = 1'b0;
        rf_wen          = 1'b0;
        illegal         = 1'b0;
        case (cur_state)
            S_INIT: next_state = S_IF;
            S_IF: begin
                inst_req_valid = 1'b1;
                if (inst_req_ready) next_state = S_IW;
            end
            S_IW: begin
                inst_ready = 1'b1;
                if (inst_valid) begin
                    pc_wen     = 1'b1;
                    next_state = S_ID;
                end
            end
            S_ID: begin
                if (!dec_ok) begin
                    illegal    = 1'b1;
                    next_state = S_IF;
                end else begin
                    next_state = S_EX;
                end
            end
            S_EX: begin
                if (is_branch) begin
                    branch     = 1'b1;
                    next_state = S_IF;
                end else if (is_jump) begin
                    pc_jump    = 1'b1;
                    next_state = S_WB;
                end else if (is_store) begin
                    next_state = S_ST;
                end else if (is_load) begin
                    next_state = S_LD;
                end else if (is_mul) begin
                    if (mul_cnt == MUL_LAST) next_state = S_WB;
                end else begin
                    next_state = S_WB;
                end
            end
            S_ST: begin
                mem_write = 1'b1;
                if (mem_req_ready) next_state = S_IF;
            end
            S_LD: begin
                mem_read = 1'b1;
                if (mem_req_ready) next_state = S_RDW;
            end
            S_RDW: begin
                read_data_ready = 1'b1;
                if (read_data_valid) next_state = S_WB;
            end
            S_WB: begin
                rf_wen     = (ir[11:7] != 5'd0);
                next_state = S_IF;
            end
            default: next_state = S_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_state <= S_INIT;
            ir        <= '0;
            cycle_cnt <= '0;
            inst_cnt  <= '0;
            mul_cnt   <= '0;
        end else begin
            cur_state <= next_state;
            cycle_cnt <= cycle_cnt + CNT_W'(1);
            if (cur_state == S_IW && inst_valid) begin
                ir       <= inst;
                inst_cnt <= inst_cnt + CNT_W'(1);
            end
            // Counts cycles already spent in EX; any other transition clears it.
            mul_cnt <= (cur_state == S_EX && next_state == S_EX) ? mul_cnt + 4'd1 : 4'd0;
        end
    end

endmodule

// File: tb/tb_rv_mc_control.sv
// Scoreboard bench for rv_mc_control: expected per-cycle controls are queued per scenario and popped each cycle.
`timescale 1ns/1ps
module tb_rv_mc_control;

    localparam logic [8:0] S_INIT = 9'h001, S_IF = 9'h002, S_IW = 9'h004, S_ID = 9'h008,
                           S_EX = 9'h010, S_ST = 9'h020, S_LD = 9'h040, S_RDW = 9'h080, S_WB = 9'h100;
    // strobe order: inst_req_valid, inst_ready, pc_wen, mem_read, mem_write, read_data_ready, branch, pc_jump, rf_wen, illegal
    localparam logic [9:0] V_IRV = 10'h200, V_IRDY = 10'h100, V_PCW = 10'h080, V_MRD = 10'h040,
                           V_MWR = 10'h020, V_RDR = 10'h010, V_BR = 10'h008, V_JMP = 10'h004,
                           V_RFW = 10'h002, V_ILL = 10'h001;
    localparam logic [10:0] A_ADD = 11'h001, A_SUB = 11'h002, A_MUL = 11'h400;
    localparam logic [4:0]  I_J = 5'h02, I_I = 5'h04, I_B = 5'h08, I_S = 5'h10;

    localparam logic [31:0] W_ADDI = 32'h00500093, W_LW = 32'h0000A103, W_SW = 32'h0020A223,
                            W_MUL = 32'h02208033, W_BEQ = 32'h00208463, W_ADDI0 = 32'h00100013,
                            W_JAL = 32'h010000EF, W_BAD = 32'hFFFFFFFF;

    typedef struct packed {
        logic [8:0]  st;
        logic [9:0]  stb;
        logic [10:0] alu;
        logic [4:0]  imm;
    } obs_t;

    obs_t exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;
    int mem_dly = 0, rd_dly = 0, mem_wait = 0, rd_wait = 0;
    logic [31:0] cur_inst = '0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, inst_req_valid, inst_req_ready, inst_valid, inst_ready;
    logic [31:0] inst, ir;
    logic        mem_read, mem_write, mem_req_ready, read_data_valid, read_data_ready;
    logic [10:0] alu_op;
    logic [4:0]  imm_sel;
    logic        pc_wen, pc_jump, branch, rf_wen, illegal;
    logic [8:0]  state;
    logic [31:0] cycle_cnt, inst_cnt;

    logic        rst_b, inst_req_valid_b, inst_ready_b, mem_read_b, mem_write_b, read_data_ready_b;
    logic [31:0] ir_b;
    logic [10:0] alu_op_b;
    logic [4:0]  imm_sel_b;
    logic        pc_wen_b, pc_jump_b, branch_b, rf_wen_b, illegal_b;
    logic [8:0]  state_b;
    logic [3:0]  cycle_cnt_b, inst_cnt_b;

    rv_mc_control #(.CNT_W(32), .M_EXT(1), .MUL_LAT(3)) dut (
        .clk(clk), .rst(rst),
        .inst_req_valid(inst_req_valid), .inst_req_ready(inst_req_ready),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .ir(ir),
        .mem_read(mem_read), .mem_write(mem_write), .mem_req_ready(mem_req_ready),
        .read_data_valid(read_data_valid), .read_data_ready(read_data_ready),
        .alu_op(alu_op), .imm_sel(imm_sel), .pc_wen(pc_wen), .pc_jump(pc_jump),
        .branch(branch), .rf_wen(rf_wen), .illegal(illegal), .state(state),
        .cycle_cnt(cycle_cnt), .inst_cnt(inst_cnt)
    );

    rv_mc_control #(.CNT_W(4), .M_EXT(0), .MUL_LAT(3)) dut_b (
        .clk(clk), .rst(rst_b),
        .inst_req_valid(inst_req_valid_b), .inst_req_ready(1'b1),
        .inst_valid(1'b1), .inst_ready(inst_ready_b), .inst(W_MUL), .ir(ir_b),
        .mem_read(mem_read_b), .mem_write(mem_write_b), .mem_req_ready(1'b1),
        .read_data_valid(1'b1), .read_data_ready(read_data_ready_b),
        .alu_op(alu_op_b), .imm_sel(imm_sel_b), .pc_wen(pc_wen_b), .pc_jump(pc_jump_b),
        .branch(branch_b), .rf_wen(rf_wen_b), .illegal(illegal_b), .state(state_b),
        .cycle_cnt(cycle_cnt_b), .inst_cnt(inst_cnt_b)
    );

    function automatic obs_t sample_a();
        obs_t o;
        o.st  = state;
        o.stb = {inst_req_valid, inst_ready, pc_wen, mem_read, mem_write, read_data_ready,
                 branch, pc_jump, rf_wen, illegal};
        o.alu = alu_op;
        o.imm = imm_sel;
        return o;
    endfunction

    function automatic obs_t sample_b();
        obs_t o;
        o.st  = state_b;
        o.stb = {inst_req_valid_b, inst_ready_b, pc_wen_b, mem_read_b, mem_write_b, read_data_ready_b,
                 branch_b, pc_jump_b, rf_wen_b, illegal_b};
        o.alu = alu_op_b;
        o.imm = imm_sel_b;
        return o;
    endfunction

    function automatic void push_exp(input logic [8:0] st, input logic [9:0] stb,
                                     input logic [10:0] alu, input logic [4:0] imm);
        obs_t e;
        e.st  = st;
        e.stb = stb;
        e.alu = alu;
        e.imm = imm;
        exp_q.push_back(e);
    endfunction

    function automatic void push_fetch();
        push_exp(S_INIT, '0, '0, '0);
        push_exp(S_IF, V_IRV, '0, '0);
        push_exp(S_IW, V_IRDY | V_PCW, '0, '0);
    endfunction

    // Memory responder: ready/valid appear after the configured number of waiting cycles.
    task automatic drive_cycle(input logic r);
        @(negedge clk);
        rst             = r;
        inst            = cur_inst;
        inst_req_ready  = 1'b1;
        inst_valid      = 1'b1;
        mem_req_ready   = (mem_read || mem_write) && (mem_wait >= mem_dly);
        read_data_valid = read_data_ready && (rd_wait >= rd_dly);
        #1;
        mem_wait = (mem_read || mem_write) ? mem_wait + 1 : 0;
        rd_wait  = read_data_ready ? rd_wait + 1 : 0;
    endtask

    task automatic apply_reset_a(input logic [31:0] word);
        @(negedge clk);
        rst             = 1'b1;
        cur_inst        = word;
        inst            = word;
        mem_wait        = 0;
        rd_wait         = 0;
        mem_req_ready   = 1'b0;
        read_data_valid = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        obs_t got;
        rst = 1'b1; inst_req_ready = 1'b1; inst_valid = 1'b1; mem_req_ready = 1'b1; read_data_valid = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        got = sample_a();
        n_tests++; if (got.st !== S_INIT) begin n_fail++; $display("FAIL reset_state: got %h want %h", got.st, S_INIT); end
        n_tests++; if (got.stb !== 10'h000) begin n_fail++; $display("FAIL reset_strobes: got %h want 000", got.stb); end
        n_tests++; if (ir !== 32'h0) begin n_fail++; $display("FAIL reset_ir: got %h want 0", ir); end
        n_tests++; if (cycle_cnt !== 32'd0 || inst_cnt !== 32'd0) begin
            n_fail++; $display("FAIL reset_counters: got %0d/%0d want 0/0", cycle_cnt, inst_cnt); end
        drive_cycle(1'b0);
        got = sample_a();
        n_tests++; if (got !== 35'({S_INIT, 10'h000, 11'h000, 5'h00})) begin
            n_fail++; $display("FAIL reset_release: got %h want INIT idle", got); end
        drive_cycle(1'b0);
        got = sample_a();
        n_tests++; if (got.st !== S_IF || got.stb !== V_IRV || cycle_cnt !== 32'd1) begin
            n_fail++; $display("FAIL reset_exit: got st %h stb %h cyc %0d want IF/%h/1", got.st, got.stb, cycle_cnt, V_IRV); end
    endtask

    task automatic test_addi();
        obs_t got, want;
        apply_reset_a(W_ADDI);
        mem_dly = 0; rd_dly = 0;
        push_fetch();
        push_exp(S_ID, '0, A_ADD, I_I);
        push_exp(S_EX, '0, A_ADD, I_I);
        push_exp(S_WB, V_RFW, A_ADD, I_I);
        push_exp(S_IF, V_IRV, '0, '0);
        while (exp_q.size() > 0) begin
            drive_cycle(1'b0);
            got = sample_a(); want = exp_q.pop_front(); n_tests++;
            if (got !== want) begin n_fail++; $display("FAIL addi_trace: got %h want %h", got, want); end
        end
        n_tests++; if (inst_cnt !== 32'd1) begin n_fail++; $display("FAIL addi_inst_cnt: got %0d want 1", inst_cnt); end
        n_tests++; if (ir !== W_ADDI) begin n_fail++; $display("FAIL addi_ir: got %h want %h", ir, W_ADDI); end
        n_tests++; if (cycle_cnt !== 32'd6) begin n_fail++; $display("FAIL addi_cycle_cnt: got %0d want 6", cycle_cnt); end
    endtask

    task automatic test_load_store();
        obs_t got, want;
        apply_reset_a(W_LW);
        mem_dly = 3; rd_dly = 2;
        push_fetch();
        push_exp(S_ID, '0, A_ADD, I_I);
        push_exp(S_EX, '0, A_ADD, I_I);
        repeat (4) push_exp(S_LD, V_MRD, A_ADD, I_I);
        repeat (3) push_exp(S_RDW, V_RDR, A_ADD, I_I);
        push_exp(S_WB, V_RFW, A_ADD, I_I);
        push_exp(S_IF, V_IRV, '0, '0);
        while (exp_q.size() > 0) begin
            drive_cycle(1'b0);
            got = sample_a(); want = exp_q.pop_front(); n_tests++;
            if (got !== want) begin n_fail++; $display("FAIL load_trace: got %h want %h", got, want); end
        end
        apply_reset_a(W_SW);
        mem_dly = 0; rd_dly = 0;
        push_fetch();
        push_exp(S_ID, '0, A_ADD, I_S);
        push_exp(S_EX, '0, A_ADD, I_S);
        push_exp(S_ST, V_MWR, A_ADD, I_S);
        push_exp(S_IF, V_IRV, '0, '0);
        while (exp_q.size() > 0) begin
            drive_cycle(1'b0);
            got = sample_a(); want = exp_q.pop_front(); n_tests++;
            if (got !== want) begin n_fail++; $display("FAIL store_trace: got %h want %h", got, want); end
        end
    endtask

    task automatic test_mul();
        obs_t got, want;
        apply_reset_a(W_MUL);
        mem_dly = 0; rd_dly = 0;
        push_fetch();
        push_exp(S_ID, '0, A_MUL, '0);
        repeat (3) push_exp(S_EX, '0, A_MUL, '0);
        push_exp(S_WB, '0, A_MUL, '0);
        push_exp(S_IF, V_IRV, '0, '0);
        while (exp_q.size() > 0) begin
            drive_cycle(1'b0);
            got = sample_a(); want = exp_q.pop_front(); n_tests++;
            if (got !== want) begin n_fail++; $display("FAIL mul_trace: got %h want %h", got, want); end
        end
        // Same word on the base-ISA instance must trap repeatedly and never write.
        @(negedge clk); rst_b = 1'b1;
        @(negedge clk); rst_b = 1'b0; #1;
        exp_q.delete();
        push_fetch();
        push_exp(S_ID, V_ILL, '0, '0);
        push_exp(S_IF, V_IRV, '0, '0);
        push_exp(S_IW, V_IRDY | V_PCW, '0, '0);
        push_exp(S_ID, V_ILL, '0, '0);
        push_exp(S_IF, V_IRV, '0, '0);
        while (exp_q.size() > 0) begin
            got = sample_b(); want = exp_q.pop_front(); n_tests++;
            if (got !== want) begin n_fail++; $display("FAIL mul_illegal_trace: got %h want %h", got, want); end
            @(negedge clk); #1;
        end
    endtask

    task automatic test_branch_jump();
        obs_t got, want;
        apply_reset_a(W_BEQ);
        push_fetch();
        push_exp(S_ID, '0, A_SUB, I_B);
        push_exp(S_EX, V_BR, A_SUB, I_B);
        push_exp(S_IF, V_IRV, '0, '0);
        while (exp_q.size() > 0) begin
            drive_cycle(1'b0);
            got = sample_a(); want = exp_q.pop_front(); n_tests++;
            if (got !== want) begin n_fail++; $display("FAIL beq_trace: got %h want %h", got, want); end
        end
        apply_reset_a(W_ADDI0);
        push_fetch();
        push_exp(S_ID, '0, A_ADD, I_I);
        push_exp(S_EX, '0, A_ADD, I_I);
        push_exp(S_WB, '0, A_ADD, I_I);
        push_exp(S_IF, V_IRV, '0, '0);
        while (exp_q.size() > 0) begin
            drive_cycle(1'b0);
            got = sample_a(); want = exp_q.pop_front(); n_tests++;
            if (got !== want) begin n_fail++; $display("FAIL addi_x0_trace: got %h want %h", got, want); end
        end
        apply_reset_a(W_JAL);
        push_fetch();
        push_exp(S_ID, '0, A_ADD, I_J);
        push_exp(S_EX, V_JMP, A_ADD, I_J);
        push_exp(S_WB, V_RFW, A_ADD, I_J);
        push_exp(S_IF, V_IRV, '0, '0);
        while (exp_q.size() > 0) begin
            drive_cycle(1'b0);
            got = sample_a(); want = exp_q.pop_front(); n_tests++;
            if (got !== want) begin n_fail++; $display("FAIL jal_trace: got %h want %h", got, want); end
        end
        apply_reset_a(W_BAD);
        push_fetch();
        push_exp(S_ID, V_ILL, '0, '0);
        push_exp(S_IF, V_IRV, '0, '0);
        while (exp_q.size() > 0) begin
            drive_cycle(1'b0);
            got = sample_a(); want = exp_q.pop_front(); n_tests++;
            if (got !== want) begin n_fail++; $display("FAIL illegal_trace: got %h want %h", got, want); end
        end
    endtask

    task automatic test_reset_in_ld();
        obs_t got, want;
        apply_reset_a(W_LW);
        mem_dly = 100; rd_dly = 0;
        push_fetch();
        push_exp(S_ID, '0, A_ADD, I_I);
        push_exp(S_EX, '0, A_ADD, I_I);
        repeat (2) push_exp(S_LD, V_MRD, A_ADD, I_I);
        while (exp_q.size() > 0) begin
            drive_cycle(1'b0);
            got = sample_a(); want = exp_q.pop_front(); n_tests++;
            if (got !== want) begin n_fail++; $display("FAIL ld_wait_trace: got %h want %h", got, want); end
        end
        drive_cycle(1'b1);
        n_tests++; if (state !== S_LD || mem_read !== 1'b1) begin
            n_fail++; $display("FAIL ld_before_rst: got st %h mrd %b want %h/1", state, mem_read, S_LD); end
        drive_cycle(1'b0);
        got = sample_a();
        n_tests++; if (got.st !== S_INIT || got.stb !== 10'h000) begin
            n_fail++; $display("FAIL ld_rst_state: got st %h stb %h want %h/000", got.st, got.stb, S_INIT); end
        n_tests++; if (cycle_cnt !== 32'd0 || inst_cnt !== 32'd0 || ir !== 32'h0) begin
            n_fail++; $display("FAIL ld_rst_regs: got cyc %0d inst %0d ir %h want 0/0/0", cycle_cnt, inst_cnt, ir); end
    endtask

    task automatic test_wrap();
        @(negedge clk); rst_b = 1'b1;
        @(negedge clk); rst_b = 1'b0;
        repeat (15) @(posedge clk);
        @(negedge clk);
        n_tests++; if (cycle_cnt_b !== 4'd15) begin n_fail++; $display("FAIL wrap_15: got %0d want 15", cycle_cnt_b); end
        @(posedge clk); @(negedge clk);
        n_tests++; if (cycle_cnt_b !== 4'd0) begin n_fail++; $display("FAIL wrap_16: got %0d want 0", cycle_cnt_b); end
        @(posedge clk); @(negedge clk);
        n_tests++; if (cycle_cnt_b !== 4'd1) begin n_fail++; $display("FAIL wrap_17: got %0d want 1", cycle_cnt_b); end
    endtask

    initial begin
        rst = 1'b1; rst_b = 1'b1;
        inst_req_ready = 1'b0; inst_valid = 1'b0; inst = '0;
        mem_req_ready = 1'b0; read_data_valid = 1'b0;
        test_reset();
        test_addi();
        test_load_store();
        test_mul();
        test_branch_jump();
        test_reset_in_ld();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
